// File: rtl/counting_gen_pkg.sv
// Shared definitions for the 01->10->11 token generator and its companion detector.
package counting_gen_pkg;

    // Two-bit symbol alphabet shared with the sequence detector
    localparam logic [1:0] SYM_NONE  = 2'b00;
    localparam logic [1:0] SYM_ONE   = 2'b01;
    localparam logic [1:0] SYM_TWO   = 2'b10;
    localparam logic [1:0] SYM_THREE = 2'b11;

    // Generator states: idle, the three token symbols, and the inter-token gap
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYM1 = 3'd1,
        ST_SYM2 = 3'd2,
        ST_SYM3 = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    // Symbol driven on the line while sitting in a given state
    function automatic logic [1:0] stateSymbol(input state_t s);
        logic [1:0] sym;
        sym = SYM_NONE;
        case (s)
            ST_SYM1: sym = SYM_ONE;
            ST_SYM2: sym = SYM_TWO;
            ST_SYM3: sym = SYM_THREE;
            default: sym = SYM_NONE;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/counting_gen_run_timer.sv
// Loadable down-counter timing how long the generator stays in its current state.
module run_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_enable,
    input  logic [W-1:0] i_loadVal,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    // Reload on state entry, otherwise count down towards 1; frozen while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (i_load) begin
                r_cnt <= i_loadVal;
            end else if (r_cnt > W'(1)) begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/counting_gen.sv
// Token stream generator: emits count tokens of 01 x run1, 10 x run2, 11 x run3,
// optionally separated by GAP_LEN cycles of 00, with hold/stall and done handshake.
module counting_gen
    import counting_gen_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter int RUN_W   = 4,
    parameter int GAP_LEN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    input  logic [RUN_W-1:0]   run1,
    input  logic [RUN_W-1:0]   run2,
    input  logic [RUN_W-1:0]   run3,
    input  logic               hold,
    output logic [1:0]         num,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    // The shared timer must be wide enough for both run lengths and the gap length
    localparam int GAP_W   = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam int TIMER_W = (GAP_W > RUN_W) ? GAP_W : RUN_W;

    state_t               r_state;
    state_t               w_nextState;
    logic [COUNT_W-1:0]   r_tokens;
    logic [RUN_W-1:0]     r_run1;
    logic [RUN_W-1:0]     r_run2;
    logic [RUN_W-1:0]     r_run3;
    logic [RUN_W-1:0]     w_run1In;
    logic [RUN_W-1:0]     w_run2In;
    logic [RUN_W-1:0]     w_run3In;
    logic                 w_accept;
    logic                 w_load;
    logic [TIMER_W-1:0]   w_loadVal;
    logic                 w_last;
    logic                 w_tokenDec;
    logic                 w_doneNext;
    logic [1:0]           w_numNext;
    logic                 w_validNext;
    logic                 w_busyNext;
    logic [1:0]           r_num;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;

    // A zero run length still holds its symbol for one cycle
    assign w_run1In = (run1 == '0) ? RUN_W'(1) : run1;
    assign w_run2In = (run2 == '0) ? RUN_W'(1) : run2;
    assign w_run3In = (run3 == '0) ? RUN_W'(1) : run3;

    // A request is only taken when idle and not stalled
    assign w_accept = (r_state == ST_IDLE) && start && !hold;

    run_timer #(
        .W(TIMER_W)
    ) u_runTimer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_enable  (!hold),
        .i_loadVal (w_loadVal),
        .o_last    (w_last)
    );

    // State register; hold is folded into the next-state logic so it simply recirculates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic, including timer reloads, token decrement and done generation
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        w_tokenDec  = 1'b0;
        w_doneNext  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (count != '0) begin
                        w_nextState = ST_SYM1;
                        w_load      = 1'b1;
                        w_loadVal   = TIMER_W'(w_run1In);
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end
            end
            ST_SYM1: begin
                if (!hold && w_last) begin
                    w_nextState = ST_SYM2;
                    w_load      = 1'b1;
                    w_loadVal   = TIMER_W'(r_run2);
                end
            end
            ST_SYM2: begin
                if (!hold && w_last) begin
                    w_nextState = ST_SYM3;
                    w_load      = 1'b1;
                    w_loadVal   = TIMER_W'(r_run3);
                end
            end
            ST_SYM3: begin
                if (!hold && w_last) begin
                    if (r_tokens == COUNT_W'(1)) begin
                        w_nextState = ST_IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_tokenDec = 1'b1;
                        w_load     = 1'b1;
                        if (GAP_LEN > 0) begin
                            w_nextState = ST_GAP;
                            w_loadVal   = TIMER_W'(GAP_LEN);
                        end else begin
                            w_nextState = ST_SYM1;
                            w_loadVal   = TIMER_W'(r_run1);
                        end
                    end
                end
            end
            ST_GAP: begin
                if (!hold && w_last) begin
                    w_nextState = ST_SYM1;
                    w_load      = 1'b1;
                    w_loadVal   = TIMER_W'(r_run1);
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so that num/valid/busy can be registered
    always_comb begin
        w_numNext   = stateSymbol(w_nextState);
        w_validNext = (w_nextState == ST_SYM1) || (w_nextState == ST_SYM2) ||
                      (w_nextState == ST_SYM3);
        w_busyNext  = (w_nextState != ST_IDLE);
    end

    // Registered outputs; done is a single-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num   <= SYM_NONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_num   <= w_numNext;
            r_valid <= w_validNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
        end
    end

    // Request configuration latch and remaining-token counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tokens <= '0;
            r_run1   <= '0;
            r_run2   <= '0;
            r_run3   <= '0;
        end else if (w_accept) begin
            r_tokens <= count;
            r_run1   <= w_run1In;
            r_run2   <= w_run2In;
            r_run3   <= w_run3In;
        end else if (w_tokenDec) begin
            r_tokens <= r_tokens - COUNT_W'(1);
        end
    end

    assign num   = r_num;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_counting_gen.sv
// Bench for counting_gen: a queue-based stream model checked every cycle, plus
// directed requests whose symbol streams and timings are pinned to literal values.
module tb_counting_gen;

    localparam int COUNT_W = 8;
    localparam int RUN_W   = 4;
    localparam int GAP_LEN = 1;

    logic               clk;
    logic               reset;
    logic               start;
    logic [COUNT_W-1:0] count;
    logic [RUN_W-1:0]   run1;
    logic [RUN_W-1:0]   run2;
    logic [RUN_W-1:0]   run3;
    logic               hold;
    logic [1:0]         num;
    logic               valid;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;
    logic checkEn = 1'b0;

    counting_gen #(
        .COUNT_W (COUNT_W),
        .RUN_W   (RUN_W),
        .GAP_LEN (GAP_LEN)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
        .run1  (run1),
        .run2  (run2),
        .run3  (run3),
        .hold  (hold),
        .num   (num),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream model: the whole request is expanded into a queue of symbols
    logic [1:0] mNum;
    logic       mActive;
    logic       mDone;
    logic [1:0] mQ[$];

    task automatic buildStream(input logic [COUNT_W-1:0] c, input logic [RUN_W-1:0] a,
                               input logic [RUN_W-1:0] b, input logic [RUN_W-1:0] d);
        int ra, rb, rd;
        ra = (a == 0) ? 1 : int'(a);
        rb = (b == 0) ? 1 : int'(b);
        rd = (d == 0) ? 1 : int'(d);
        mQ.delete();
        for (int t = 0; t < int'(c); t++) begin
            for (int i = 0; i < ra; i++) mQ.push_back(2'b01);
            for (int i = 0; i < rb; i++) mQ.push_back(2'b10);
            for (int i = 0; i < rd; i++) mQ.push_back(2'b11);
            if (t < int'(c) - 1)
                for (int i = 0; i < GAP_LEN; i++) mQ.push_back(2'b00);
        end
    endtask

    // Model advances one symbol per unstalled clock; reset wipes it at once
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mQ.delete();
            mNum    = 2'b00;
            mActive = 1'b0;
            mDone   = 1'b0;
        end else begin
            mDone = 1'b0;
            if (hold) begin
                mDone = 1'b0;
            end else if (mActive) begin
                if (mQ.size() > 0) begin
                    mNum = mQ.pop_front();
                end else begin
                    mNum    = 2'b00;
                    mActive = 1'b0;
                    mDone   = 1'b1;
                end
            end else if (start) begin
                if (count == 0) begin
                    mDone = 1'b1;
                end else begin
                    buildStream(count, run1, run2, run3);
                    mNum    = mQ.pop_front();
                    mActive = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the stream model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("num",   64'(num),   64'(mNum));
            checkOutput("valid", 64'(valid), 64'(mActive && (mNum != 2'b00)));
            checkOutput("busy",  64'(busy),  64'(mActive));
            checkOutput("done",  64'(done),  64'(mDone));
        end
    end

    // Present a one-cycle start; returns just after the accepting edge
    task automatic applyStimulus(input logic [COUNT_W-1:0] c, input logic [RUN_W-1:0] a,
                                 input logic [RUN_W-1:0] b, input logic [RUN_W-1:0] d);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = c;
        run1  = a;
        run2  = b;
        run3  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        count = '0;
        run1  = '0;
        run2  = '0;
        run3  = '0;
    endtask

    // Record busy symbols until done; bounded by maxCycles
    task automatic collectUntilDone(input int maxCycles, output logic [63:0] packedSyms,
                                    output int nBusy, output int nCycles, output logic gotDone);
        packedSyms = '0;
        nBusy      = 0;
        nCycles    = 0;
        gotDone    = 1'b0;
        while (!gotDone && nCycles < maxCycles) begin
            @(negedge clk);
            nCycles++;
            if (busy) begin
                packedSyms = {packedSyms[61:0], num};
                nBusy++;
            end
            if (done) gotDone = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    logic [63:0] got;
    int          nBusy;
    int          nCycles;
    logic        gotDone;
    int          sym2Seen;
    int          holdCnt;
    int          doneCnt;
    logic        found;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        count = '0;
        run1  = '0;
        run2  = '0;
        run3  = '0;
        #2 reset = 1'b1;
        #9;
        checkOutput("resetNum",   64'(num),   64'd0);
        checkOutput("resetValid", 64'(valid), 64'd0);
        checkOutput("resetBusy",  64'(busy),  64'd0);
        checkOutput("resetDone",  64'(done),  64'd0);
        #1 reset = 1'b0;
        checkEn = 1'b1;

        $display("[TB] single token, unit runs");
        applyStimulus(8'd1, 4'd1, 4'd1, 4'd1);
        collectUntilDone(50, got, nBusy, nCycles, gotDone);
        checkOutput("t1Stream", got, 64'h1B);
        checkOutput("t1Done",   64'(gotDone), 64'd1);
        checkOutput("t1Cycles", 64'(nCycles), 64'd4);
        checkOutput("t1Busy",   64'(nBusy),   64'd3);

        $display("[TB] two tokens with gap");
        applyStimulus(8'd2, 4'd2, 4'd1, 4'd3);
        collectUntilDone(50, got, nBusy, nCycles, gotDone);
        checkOutput("t2Stream", got, 64'({2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00,
                                          2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11}));
        checkOutput("t2Done",   64'(gotDone), 64'd1);
        checkOutput("t2Busy",   64'(nBusy),   64'd13);
        checkOutput("t2Cycles", 64'(nCycles), 64'd14);

        $display("[TB] zero-count request");
        applyStimulus(8'd0, 4'd1, 4'd1, 4'd1);
        collectUntilDone(10, got, nBusy, nCycles, gotDone);
        checkOutput("t3Done",   64'(gotDone), 64'd1);
        checkOutput("t3Cycles", 64'(nCycles), 64'd1);
        checkOutput("t3Busy",   64'(nBusy),   64'd0);

        $display("[TB] hold during second SYM2, start while busy");
        applyStimulus(8'd3, 4'd1, 4'd1, 4'd1);
        got = '0; nBusy = 0; nCycles = 0; gotDone = 1'b0; sym2Seen = 0; holdCnt = 0;
        while (!gotDone && nCycles < 60) begin
            @(negedge clk);
            nCycles++;
            if (busy) begin
                got = {got[61:0], num};
                nBusy++;
            end
            if (done) gotDone = 1'b1;
            if (holdCnt > 0) begin
                holdCnt--;
                if (holdCnt == 0) begin
                    hold  = 1'b0;
                    start = 1'b0;
                    count = '0;
                end
            end else if (num == 2'b10 && sym2Seen < 2) begin
                sym2Seen++;
                if (sym2Seen == 2) begin
                    hold    = 1'b1;
                    start   = 1'b1;
                    count   = 8'd9;
                    holdCnt = 2;
                end
            end
        end
        checkOutput("t4Stream", got, 64'({2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10,
                                          2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11}));
        checkOutput("t4Done",   64'(gotDone), 64'd1);
        checkOutput("t4Cycles", 64'(nCycles), 64'd14);

        $display("[TB] reset mid-SYM3");
        applyStimulus(8'd5, 4'd1, 4'd1, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (num == 2'b11) found = 1'b1;
        end
        checkOutput("t5FoundSym3", 64'(found), 64'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5Num",   64'(num),   64'd0);
        checkOutput("t5Busy",  64'(busy),  64'd0);
        checkOutput("t5Valid", 64'(valid), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("t5NoDone", 64'(done), 64'd0);
        applyStimulus(8'd1, 4'd2, 4'd1, 4'd1);
        collectUntilDone(50, got, nBusy, nCycles, gotDone);
        checkOutput("t5Stream", got, 64'h5B);
        checkOutput("t5Done",   64'(gotDone), 64'd1);

        $display("[TB] zero run lengths");
        applyStimulus(8'd2, 4'd0, 4'd3, 4'd0);
        collectUntilDone(50, got, nBusy, nCycles, gotDone);
        checkOutput("t6Stream", got, 64'({2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00,
                                          2'b01, 2'b10, 2'b10, 2'b10, 2'b11}));
        checkOutput("t6Busy", 64'(nBusy), 64'd11);

        $display("[TB] start ignored under hold in idle");
        @(posedge clk);
        #1;
        hold  = 1'b1;
        start = 1'b1;
        count = 8'd1;
        run1  = 4'd1;
        run2  = 4'd1;
        run3  = 4'd1;
        @(posedge clk);
        #1;
        hold  = 1'b0;
        start = 1'b0;
        count = '0;
        nBusy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) nBusy++;
        end
        checkOutput("t8Busy", 64'(nBusy), 64'd0);

        $display("[TB] start held high, back-to-back requests");
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 8'd1;
        run1  = 4'd1;
        run2  = 4'd1;
        run3  = 4'd1;
        @(posedge clk);
        got = '0;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got = {got[61:0], num};
            if (done) doneCnt++;
        end
        start = 1'b0;
        count = '0;
        checkOutput("t7Stream", got, 64'h6C6C);
        checkOutput("t7Dones",  64'(doneCnt), 64'd2);
        repeat (6) @(negedge clk);
        checkOutput("t7Idle", 64'(busy), 64'd0);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counting_gen.md
Name: counting_gen

Overview:
- Transmitter-side companion of the 2-bit "01→10→11" sequence detector.
- On a start request it drives a 2-bit symbol stream on num. Each token is symbol 01 for run1 cycles, then 10 for run2 cycles, then 11 for run3 cycles.
- Tokens repeat count times, with optional 00 gap symbols between them.
- Sits upstream of the detector (num→num, same clk) and serves as the stimulus source for detector-pipeline tests.

Parameters:
- COUNT_W, 8, width of token-count request; up to 2^COUNT_W−1 tokens.
- RUN_W, 4, width of per-symbol run-length fields.
- GAP_LEN, 1, number of 00 cycles inserted between consecutive tokens; 0 means tokens are back-to-back.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request pulse; sampled only when busy=0.
- count  in  COUNT_W  number of tokens to emit; latched on accepted start.
- run1  in  RUN_W  cycles to hold symbol 01; latched on accepted start.
- run2  in  RUN_W  cycles to hold symbol 10; latched on accepted start.
- run3  in  RUN_W  cycles to hold symbol 11; latched on accepted start.
- hold  in  1  stall; while 1, state, counters and num are frozen.
- num  out  2  emitted symbol; registered.
- valid  out  1  1 while num carries a token symbol (01/10/11); 0 in IDLE/GAP.
- busy  out  1  1 from the cycle after start is accepted until the done cycle.
- done  out  1  one-cycle pulse marking end of request; registered.

Behaviour:
- Reset (async, any time, including mid-stream):
  - state=IDLE, num=00, valid=0, busy=0, done=0.
  - All latched config and counters are cleared.
  - No done pulse is generated for an aborted request.
- States are IDLE, SYM1, SYM2, SYM3, GAP. Output mapping:
  - num: IDLE/GAP=00, SYM1=01, SYM2=10, SYM3=11.
  - valid=1 only in SYMx.
  - busy=1 in every state except IDLE.
- Run-length values of 0 are treated as 1 (min one cycle per symbol).
- Accept and latency:
  - start=1 at edge k while IDLE, busy=0, hold=0 → config latched at k.
  - If count≠0: num=01 from after edge k (zero extra latency).
  - If count=0: stay IDLE, done=1 for the cycle after k, busy stays 0.
- Symbol sequencing:
  - SYM1 lasts run1 cycles, then SYM2.
  - SYM2 lasts run2 cycles, then SYM3.
  - SYM3 lasts run3 cycles. After that:
    - if tokens remain and GAP_LEN>0 → GAP for GAP_LEN cycles, then SYM1;
    - if tokens remain and GAP_LEN=0 → SYM1 directly;
    - if this was the last token → IDLE with done=1 in the first IDLE cycle. No trailing gap.
- Counters:
  - One run counter, reloaded on every state entry.
  - One token counter, decremented at the end of each SYM3.
  - Both are frozen while hold=1.
- hold:
  - hold=1 freezes everything, including mid-run and in GAP.
  - num/valid/busy keep their values; a pending done is not issued until hold drops.
  - start asserted while hold=1 in IDLE is ignored.
- start while busy=1 is ignored; config inputs are don't-care after the latch edge.
- done and start in the same cycle: done is on the first IDLE cycle, so a new start is accepted in that same cycle (back-to-back requests).
- Total busy cycles for a request = count·(r1+r2+r3) + (count−1)·GAP_LEN, where rX = max(runX,1).

Decomposition:
- Shared package: symbol codes SYM_NONE=00, SYM_ONE=01, SYM_TWO=10, SYM_THREE=11, used by both the detector and this block.
- Shared package: state encodings for counting_gen.
- One natural sub-module, run_timer: loadable down-counter with load, enable (=~hold) and last (count==1) output. It is instantiated once for symbol/gap durations.

Test Plan:
- start, count=1, run1=run2=run3=1 → num 01,10,11 on three consecutive cycles; done at cycle 4; a connected detector's ans=1 exactly on the cycle after the 11 symbol.
- count=2, run1=2, run2=1, run3=3, GAP_LEN=1 → 01,01,10,11,11,11,00,01,01,10,11,11,11; then done; busy high for 13 cycles.
- count=0 → no valid cycles, done pulse one cycle after start, busy never asserts.
- count=3, runs=1, hold=1 for 2 cycles during the second SYM2 → 10 repeated 3 cycles total; stream otherwise unchanged; done delayed by 2 cycles.
- reset=1 mid-SYM3 of count=5 → num=00, busy=0 immediately (before the next edge); no done; a new start after release begins with 01.
- start held high continuously, count=1, runs=1, GAP_LEN=0 → a new request is accepted on every done cycle; pattern 01,10,11 repeats with exactly one 00 (IDLE) cycle between requests.
